ccd_phase_decoder: RTL

- Receive-side counterpart of the CCD clock sequencer.
- Consumes the four CCD phases `phi_r`, `phi_p`, `phi_l1` and `phi_l2`, decodes the pixel and line structure from them, and issues correlated-double-sampling strobes to the ADC front end.
- Maintains pixel and line counters.
- Flags phase-protocol violations: L1/L2 overlap, out-of-order reset, and missing transfer.

---
 rtl/ccd_phase_decoder_if.sv | 37 +++
 rtl/ccd_phase_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ccd_phase_decoder_if.sv
// Signal bundle between the CCD phase pins/configuration and the phase decoder.
// The decoder attaches through the slave modport and the phase source through the master modport.
interface ccd_phase_decoder_if #(
    parameter int PIX_W  = 12,
    parameter int LINE_W = 12
);
    logic              enable;
    logic              phi_p;
    logic              phi_l1;
    logic              phi_l2;
    logic              phi_r;
    logic [7:0]        rst_settle;
    logic [7:0]        sig_settle;
    logic              clr_err;
    logic              shs_rst;
    logic              shs_sig;
    logic              pixel_valid;
    logic              line_start;
    logic [PIX_W-1:0]  pixel_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic              err_overlap;
    logic              err_seq;
    logic              err_timeout;
    logic [2:0]        state;

    modport master (
        output enable, phi_p, phi_l1, phi_l2, phi_r, rst_settle, sig_settle, clr_err,
        input  shs_rst, shs_sig, pixel_valid, line_start, pixel_cnt, line_cnt,
               err_overlap, err_seq, err_timeout, state
    );

    modport slave (
        input  enable, phi_p, phi_l1, phi_l2, phi_r, rst_settle, sig_settle, clr_err,
        output shs_rst, shs_sig, pixel_valid, line_start, pixel_cnt, line_cnt,
               err_overlap, err_seq, err_timeout, state
    );
endinterface

// File: rtl/ccd_phase_decoder.sv
// Decodes CCD phases into CDS sample strobes, pixel/line counts and sticky protocol-error flags.
//
// state      | meaning
// IDLE       | waiting for a phi_r rise to start a pixel
// RST_HI     | reset gate high, waiting for phi_r to fall
// RST_SETTLE | counting down rst_settle before the reset-level sample
// WAIT_L2    | waiting for phi_l2 rise (charge dump), timeout counter running
// SIG_SETTLE | counting down sig_settle before the signal-level sample
module ccd_phase_decoder #(
    parameter int              PIX_W   = 12,
    parameter int              LINE_W  = 12,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    ccd_phase_decoder_if.slave io_bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RST_HI     = 3'd1,
        RST_SETTLE = 3'd2,
        WAIT_L2    = 3'd3,
        SIG_SETTLE = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_settle, w_settle_nxt;
    logic [TO_W-1:0]   r_to_cnt, w_to_nxt, w_to_inc;
    logic [3:0]        r_ph1;      // {phi_p, phi_l1, phi_l2, phi_r}
    logic [2:0]        r_ph2;      // {phi_p, phi_l2, phi_r}
    logic              w_r_rise, w_r_fall, w_l2_rise, w_p_rise, w_overlap_evt;
    logic              w_shs_rst_nxt, w_shs_sig_nxt, w_seq_evt, w_to_evt;
    logic              r_shs_rst, r_shs_sig, r_pixel_valid, r_line_start;
    logic [PIX_W-1:0]  r_pixel_cnt;
    logic [LINE_W-1:0] r_line_cnt;
    logic              r_err_overlap, r_err_seq, r_err_timeout;

    assign w_r_rise      = r_ph1[0] & ~r_ph2[0];
    assign w_r_fall      = ~r_ph1[0] & r_ph2[0];
    assign w_l2_rise     = r_ph1[1] & ~r_ph2[1];
    assign w_p_rise      = r_ph1[3] & ~r_ph2[2];
    assign w_overlap_evt = io_bus.enable & r_ph1[2] & r_ph1[1];
    assign w_to_inc      = r_to_cnt + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_settle_nxt  = r_settle;
        w_to_nxt      = r_to_cnt;
        w_shs_rst_nxt = 1'b0;
        w_shs_sig_nxt = 1'b0;
        w_seq_evt     = 1'b0;
        w_to_evt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_r_rise) w_state_nxt = RST_HI;
            end
            RST_HI: begin
                if (w_r_fall) begin
                    w_state_nxt  = RST_SETTLE;
                    w_settle_nxt = io_bus.rst_settle;
                end
            end
            RST_SETTLE: begin
                if (w_r_rise) begin
                    w_seq_evt   = 1'b1;
                    w_state_nxt = RST_HI;
                end else if (r_settle == 8'd0) begin
                    w_shs_rst_nxt = 1'b1;
                    w_state_nxt   = WAIT_L2;
                    w_to_nxt      = '0;
                end else begin
                    w_settle_nxt = r_settle - 8'd1;
                end
            end
            WAIT_L2: begin
                // A new reset pulse wins over a charge dump arriving on the same edge.
                if (w_r_rise) begin
                    w_seq_evt   = 1'b1;
                    w_state_nxt = RST_HI;
                end else if (w_l2_rise) begin
                    w_state_nxt  = SIG_SETTLE;
                    w_settle_nxt = io_bus.sig_settle;
                end else if (w_to_inc == TIMEOUT) begin
                    w_to_evt    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_to_nxt = w_to_inc;
                end
            end
            SIG_SETTLE: begin
                if (w_r_rise) begin
                    w_seq_evt   = 1'b1;
                    w_state_nxt = RST_HI;
                end else if (r_settle == 8'd0) begin
                    w_shs_sig_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_settle_nxt = r_settle - 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!io_bus.enable) begin
            w_state_nxt   = IDLE;
            w_settle_nxt  = '0;
            w_to_nxt      = '0;
            w_shs_rst_nxt = 1'b0;
            w_shs_sig_nxt = 1'b0;
            w_seq_evt     = 1'b0;
            w_to_evt      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_settle <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= w_settle_nxt;
            r_to_cnt <= w_to_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ph1         <= '0;
            r_ph2         <= '0;
            r_shs_rst     <= 1'b0;
            r_shs_sig     <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_line_start  <= 1'b0;
            r_pixel_cnt   <= '0;
            r_line_cnt    <= '0;
            r_err_overlap <= 1'b0;
            r_err_seq     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_ph1         <= {io_bus.phi_p, io_bus.phi_l1, io_bus.phi_l2, io_bus.phi_r};
            r_ph2         <= {r_ph1[3], r_ph1[1], r_ph1[0]};
            r_shs_rst     <= w_shs_rst_nxt;
            r_shs_sig     <= w_shs_sig_nxt;
            r_pixel_valid <= w_shs_sig_nxt;
            if (!io_bus.enable) begin
                r_line_start <= 1'b0;
                r_pixel_cnt  <= '0;
                r_line_cnt   <= '0;
            end else begin
                r_line_start <= w_p_rise;
                // Line boundary clear takes priority over a pixel completing on the same edge.
                if (w_p_rise) begin
                    r_line_cnt  <= r_line_cnt + 1'b1;
                    r_pixel_cnt <= '0;
                end else if (w_shs_sig_nxt) begin
                    r_pixel_cnt <= r_pixel_cnt + 1'b1;
                end
            end
            r_err_overlap <= w_overlap_evt | (r_err_overlap & ~io_bus.clr_err);
            r_err_seq     <= w_seq_evt     | (r_err_seq     & ~io_bus.clr_err);
            r_err_timeout <= w_to_evt      | (r_err_timeout & ~io_bus.clr_err);
        end
    end

    assign io_bus.shs_rst     = r_shs_rst;
    assign io_bus.shs_sig     = r_shs_sig;
    assign io_bus.pixel_valid = r_pixel_valid;
    assign io_bus.line_start  = r_line_start;
    assign io_bus.pixel_cnt   = r_pixel_cnt;
    assign io_bus.line_cnt    = r_line_cnt;
    assign io_bus.err_overlap = r_err_overlap;
    assign io_bus.err_seq     = r_err_seq;
    assign io_bus.err_timeout = r_err_timeout;
    assign io_bus.state       = r_state;
endmodule
